// File: rtl/uart_dump_pkg.sv
// Shared types for the uart_dump RIB-to-UART memory dumper: FSM encodings,
// frame length and the byte-lane helper.
package uart_dump_pkg;

  typedef enum logic [2:0] {
    UD_IDLE = 3'd0,
    UD_RD   = 3'd1,
    UD_TX   = 3'd2,
    UD_CK   = 3'd3,
    UD_FIN  = 3'd4
  } ud_state_e;

  // start + 8 data + stop
  localparam int UD_FRAME_BITS = 10;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] sel);
    return w[8*sel +: 8];
  endfunction

endpackage

// File: rtl/uart_dump_tx_byte.sv
// 8N1 byte serializer. ready_o is also high in the last cycle of the stop bit,
// so a byte offered then starts its start bit with no idle gap.
module uart_tx_byte
  import uart_dump_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [3:0] STOP_BIT = 4'(UD_FRAME_BITS - 1);

  logic              busy_q, busy_d;
  logic              tx_q, tx_d;
  logic [8:0]        sh_q, sh_d;
  logic [3:0]        bit_q, bit_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic              bit_end, last_cycle;

  assign bit_end    = busy_q && (baud_q == BAUD_LAST);
  assign last_cycle = bit_end && (bit_q == STOP_BIT);
  assign ready_o    = !busy_q || last_cycle;
  assign tx_o       = tx_q;

  always_comb begin
    busy_d = busy_q;
    tx_d   = tx_q;
    sh_d   = sh_q;
    bit_d  = bit_q;
    baud_d = baud_q;
    if (valid_i && ready_o) begin
      // sh holds the stop bit above the data so the shift ends on a 1
      busy_d = 1'b1;
      tx_d   = 1'b0;
      sh_d   = {1'b1, byte_i};
      bit_d  = 4'd0;
      baud_d = '0;
    end else if (last_cycle) begin
      busy_d = 1'b0;
      tx_d   = 1'b1;
      baud_d = '0;
    end else if (bit_end) begin
      baud_d = '0;
      bit_d  = bit_q + 4'd1;
      tx_d   = sh_q[0];
      sh_d   = {1'b1, sh_q[8:1]};
    end else if (busy_q) begin
      baud_d = baud_q + BAUD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= 1'b0;
      tx_q   <= 1'b1;
      sh_q   <= '0;
      bit_q  <= '0;
      baud_q <= '0;
    end else begin
      busy_q <= busy_d;
      tx_q   <= tx_d;
      sh_q   <= sh_d;
      bit_q  <= bit_d;
      baud_q <= baud_d;
    end
  end

endmodule

// File: rtl/uart_dump.sv
// RIB master that reads word_cnt_i words from start_addr_i and streams them out 8N1.
// Optional trailing mod-256 checksum frame when UART_DUMP_CKSUM_EN is defined.
module uart_dump
  import uart_dump_pkg::*;
#(
  parameter int BAUD_DIV    = 434,
  parameter int MEM_RD_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] start_addr_i,
  input  logic [15:0] word_cnt_i,
  output logic        req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        tx_pin,
  output logic        busy_o,
  output logic        done_o,
  output logic [2:0]  dbg_state_o
);

  localparam int WAIT_W = $clog2(MEM_RD_WAIT + 2);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_RD_WAIT);
`ifdef UART_DUMP_CKSUM_EN
  localparam ud_state_e AFTER_WORDS = UD_CK;
`else
  localparam ud_state_e AFTER_WORDS = UD_FIN;
`endif

  ud_state_e         state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic [WAIT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [2:0]        byte_sel_q, byte_sel_d;
  logic              done_q, done_d;
  logic              tx_valid, tx_ready;
  logic [7:0]        tx_byte;
`ifdef UART_DUMP_CKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  // Handshake: a byte moves to the serializer in a cycle where tx_valid && tx_ready.
  // byte_sel counts accepted bytes; at 4 (or 1 in CK) we wait for the frame to drain.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    rd_cnt_d   = rd_cnt_q;
    byte_sel_d = byte_sel_q;
    done_d     = 1'b0;
    req_o      = 1'b0;
    tx_valid   = 1'b0;
    tx_byte    = byte_of(word_q, byte_sel_q[1:0]);
`ifdef UART_DUMP_CKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      UD_IDLE: begin
        if (start_i) begin
          addr_d     = start_addr_i & 32'hFFFF_FFFC;
          cnt_d      = word_cnt_i;
          rd_cnt_d   = '0;
          byte_sel_d = 3'd0;
`ifdef UART_DUMP_CKSUM_EN
          sum_d      = 8'd0;
`endif
          state_d    = (word_cnt_i == 16'd0) ? AFTER_WORDS : UD_RD;
        end
      end
      UD_RD: begin
        req_o = 1'b1;
        if (rd_cnt_q == WAIT_LAST) begin
          word_d   = mem_rdata_i;
          rd_cnt_d = '0;
          state_d  = UD_TX;
        end else begin
          rd_cnt_d = rd_cnt_q + WAIT_W'(1);
        end
      end
      UD_TX: begin
        if (!byte_sel_q[2]) begin
          tx_valid = 1'b1;
          if (tx_ready) begin
            byte_sel_d = byte_sel_q + 3'd1;
`ifdef UART_DUMP_CKSUM_EN
            sum_d      = sum_q + tx_byte;
`endif
          end
        end else if (tx_ready) begin
          byte_sel_d = 3'd0;
          addr_d     = addr_q + 32'd4;
          cnt_d      = cnt_q - 16'd1;
          state_d    = (cnt_q == 16'd1) ? AFTER_WORDS : UD_RD;
        end
      end
`ifdef UART_DUMP_CKSUM_EN
      UD_CK: begin
        tx_byte = sum_q;
        if (byte_sel_q == 3'd0) begin
          tx_valid = 1'b1;
          if (tx_ready) byte_sel_d = 3'd1;
        end else if (tx_ready) begin
          byte_sel_d = 3'd0;
          state_d    = UD_FIN;
        end
      end
`endif
      UD_FIN: begin
        // first FIN cycle arms done_o, second one shows it and leaves
        if (!done_q) done_d  = 1'b1;
        else         state_d = UD_IDLE;
      end
      default: state_d = UD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= UD_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      rd_cnt_q   <= '0;
      byte_sel_q <= '0;
      done_q     <= 1'b0;
`ifdef UART_DUMP_CKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      rd_cnt_q   <= rd_cnt_d;
      byte_sel_q <= byte_sel_d;
      done_q     <= done_d;
`ifdef UART_DUMP_CKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .byte_i  (tx_byte),
    .valid_i (tx_valid),
    .ready_o (tx_ready),
    .tx_o    (tx_pin)
  );

  assign mem_we_o    = 1'b0;
  assign mem_wdata_o = 32'd0;
  assign mem_addr_o  = addr_q;
  assign busy_o      = (state_q != UD_IDLE);
  assign done_o      = done_q;
  assign dbg_state_o = state_q;

endmodule
